apb_master: RTL

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
//
// Queues read/write commands in a small FIFO and replays them, one at a time
// and in arrival order, as APB transfers. Each transfer is a SETUP cycle
// (psel=1, penable=0) followed by an ACCESS cycle (psel=1, penable=1). Writes
// then pulse wr_done. Reads go through one more CAPTURE cycle, because the
// slave registers prdata and presents it only in the cycle after ACCESS.
// After that cycle rsp_valid pulses with the captured word. There is always
// at least one cycle with psel=0 between two transfers.
//
// Parameters
//   DEPTH      command FIFO depth in entries (power of two, >= 2)
//
// Ports
//   clk        single clock, all state changes on its rising edge
//   rst        synchronous active-high reset
//   cmd_valid  command offered this cycle
//   cmd_ready  FIFO has room; the command is taken when cmd_valid && cmd_ready
//   cmd_write  1 = write, 0 = read
//   cmd_addr   8-bit target word address
//   cmd_wdata  32-bit write data (ignored for reads)
//   paddr      APB address       (registered, held between transfers)
//   pwrite     APB direction     (registered, held between transfers)
//   psel       APB select        (registered)
//   penable    APB enable        (registered)
//   pwdata     APB write data    (registered, 0 for reads)
//   prdata     APB read data, valid the cycle after ACCESS
//   rsp_valid  one-cycle pulse: rsp_rdata holds fresh read data
//   rsp_rdata  last captured read data, held until the next read completes
//   wr_done    one-cycle pulse: a write transfer completed
//   busy       FSM not idle or FIFO not empty (combinational)
// -----------------------------------------------------------------------------
module apb_master #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic [7:0]  paddr,
  output logic        pwrite,
  output logic        psel,
  output logic        penable,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        wr_done,
  output logic        busy
);

  // Pointer width. Because DEPTH is a power of two, the pointers wrap
  // modulo DEPTH simply by overflowing. The count needs one more bit so it
  // can represent "full".
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    CAPTURE = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  logic          fifo_write_q [DEPTH];
  logic [7:0]    fifo_addr_q  [DEPTH];
  logic [31:0]   fifo_wdata_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic          push_s;
  logic          pop_s;
  logic          head_write_s;
  logic [7:0]    head_addr_s;
  logic [31:0]   head_wdata_s;

  state_e        state_q, state_d;

  assign cmd_ready = (count_q < DEPTH_C);
  assign push_s    = cmd_valid && cmd_ready;
  // The head is consumed only by the IDLE -> SETUP step, so popping is
  // tied directly to "idle and something queued".
  assign pop_s     = (state_q == IDLE) && (count_q != CNT_ZERO);

  assign head_write_s = fifo_write_q[rd_ptr_q];
  assign head_addr_s  = fifo_addr_q[rd_ptr_q];
  assign head_wdata_s = fifo_wdata_q[rd_ptr_q];

  // FIFO storage. Entries need no reset: the pointers and count decide
  // which entries are live.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_write_q[wr_ptr_q] <= cmd_write;
      fifo_addr_q[wr_ptr_q]  <= cmd_addr;
      fifo_wdata_q[wr_ptr_q] <= cmd_wdata;
    end
  end

  // Next pointer and count values. A push and a pop in the same cycle
  // cancel out in the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------------
  logic [7:0]  paddr_q,     paddr_d;
  logic        pwrite_q,    pwrite_d;
  logic        psel_q,      psel_d;
  logic        penable_q,   penable_d;
  logic [31:0] pwdata_q,    pwdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        wr_done_q,   wr_done_d;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic. After ACCESS the direction is taken from pwrite_q,
  // which still holds the transfer's direction.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pop_s) begin
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (pwrite_q) begin
          state_d = IDLE;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output logic. These are the next values of the registered APB and
  // response outputs. Address, direction and write data default to holding,
  // so they stay stable through SETUP and ACCESS and keep their last values
  // afterwards.
  always_comb begin
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_rdata_d = rsp_rdata_q;
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    rsp_valid_d = 1'b0;
    wr_done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop_s) begin
          paddr_d  = head_addr_s;
          pwrite_d = head_write_s;
          pwdata_d = head_write_s ? head_wdata_s : 32'h0000_0000;
          psel_d   = 1'b1;
        end else begin
          psel_d   = 1'b0;
        end
      end
      SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      ACCESS: begin
        wr_done_d = pwrite_q;
      end
      CAPTURE: begin
        rsp_rdata_d = prdata;
        rsp_valid_d = 1'b1;
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      paddr_q     <= 8'h00;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwdata_q    <= 32'h0000_0000;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      wr_done_q   <= 1'b0;
    end else begin
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      wr_done_q   <= wr_done_d;
    end
  end

  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign wr_done   = wr_done_q;

  assign busy = (state_q != IDLE) || (count_q != CNT_ZERO);

endmodule
